mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- XLEN, 32, address and data width.
- MAX_STREAK, 4, consecutive data grants allowed while an instruction request waits.
- TIMEOUT, 255, memory-wait cycles before abort; legal range 1..65535.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1: single clock, all state on rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_inst_req, in, 1: fetch request.
- i_inst_addr, in, XLEN: fetch address.
- o_inst_ack, out, 1: fetch completion pulse.
- o_inst_rdata, out, XLEN: fetched word.
- o_inst_err, out, 1: fetch aborted by timeout; valid with o_inst_ack.
- i_data_req, in, 1: load/store request.
- i_data_addr, in, XLEN: load/store address.
- i_data_wdata, in, XLEN: store data.
- i_data_funct3, in, 3: access size/sign.
- i_data_we, in, 1: 1 = write, 0 = read.
- o_data_ack, out, 1: load/store completion pulse.
- o_data_rdata, out, XLEN: load data.
- o_data_err, out, 1: load/store aborted by timeout; valid with o_data_ack.
- o_mem_req, out, 1: shared memory port request.
- o_mem_addr, out, XLEN: shared port address.
- o_mem_wdata, out, XLEN: shared port write data.
- o_mem_funct3, out, 3: shared port access size.
- o_mem_we, out, 1: shared port write enable.
- i_mem_ack, in, 1: memory completion.
- i_mem_rdata, in, XLEN: memory read data.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: IDLE, INST, DATA, RESP.

REQ-005 Arbitration SHALL occur only in IDLE, using i_inst_req and i_data_req sampled at the clock edge.

REQ-006 When only one request is high, that request SHALL be granted.

REQ-007 When both requests are high:
- DATA SHALL be granted if streak < MAX_STREAK.
- Otherwise INST SHALL be granted.

REQ-008 The 16-bit streak counter SHALL:
- increment on a DATA grant made while i_inst_req is high;
- clear on any INST grant;
- clear on any IDLE cycle in which i_inst_req is low;
- saturate at MAX_STREAK.

REQ-009 On a grant, the following SHALL take effect at the same edge as the state change to INST or DATA:
- o_mem_req = 1;
- the granted requester's address/wdata/funct3/we are latched onto the o_mem_* outputs.

REQ-010 An INST grant SHALL drive o_mem_funct3 = 3'b010, o_mem_we = 0 and o_mem_wdata = 0.

REQ-011 In INST/DATA, o_mem_req and all o_mem_* outputs SHALL stay stable until i_mem_ack is sampled high. Requester inputs are ignored once granted.

REQ-012 When i_mem_ack is sampled high in INST/DATA:
- next state is RESP;
- o_mem_req = 0;
- the owner's rdata register captures i_mem_rdata;
- the owner's ack = 1 and err = 0.

REQ-013 RESP SHALL last exactly one cycle, then return to IDLE. The ack is therefore a one-cycle pulse.

REQ-014 The non-owner's ack, err and rdata SHALL be unchanged by the transaction.

REQ-015 Requesters SHALL drop req within one cycle of seeing their ack. A req still high in the following IDLE cycle SHALL be treated as a new request.

REQ-016 Timeout behaviour:
- The wait counter SHALL clear on grant and increment each INST/DATA cycle without ack.
- When it reaches TIMEOUT, next state is RESP with o_mem_req = 0, owner ack = 1, err = 1 and rdata = 0.

REQ-017 If i_mem_ack and timeout expiry coincide, the ack SHALL take precedence (err = 0, data captured).

REQ-018 i_mem_ack sampled in IDLE or RESP SHALL be ignored, with no state or output change.

REQ-019 Minimum transaction time SHALL be 3 cycles: grant edge, ack edge, RESP. Maximum SHALL be TIMEOUT + 2 cycles.

Reset
REQ-020 When i_rst is sampled high, the next edge SHALL force:
- state IDLE;
- streak = 0 and wait counter = 0;
- o_mem_req = 0, o_mem_we = 0;
- every other output = 0.

REQ-021 Reset in INST/DATA SHALL abandon the transaction with no ack or err pulse. A late i_mem_ack after reset is covered by REQ-018.

REQ-022 No request SHALL be granted in any cycle in which i_rst is high.

Verification
REQ-023 Single fetch: i_inst_req with addr 0x100; memory acks 2 cycles after o_mem_req with 0x00500093 -> o_mem_addr = 0x100, funct3 = 010, we = 0; one-cycle o_inst_ack with o_inst_rdata = 0x00500093, o_inst_err = 0.

REQ-024 Contention: both requests high continuously, MAX_STREAK = 4, memory acks in 1 cycle -> grant order D, D, D, D, I, D, D, D, D, I.

REQ-025 Store: data req with addr 0x2000, wdata 0xDEADBEEF, funct3 = 000, we = 1 -> o_mem_* match exactly; o_data_ack pulses; o_inst_ack stays 0.

REQ-026 Timeout: TIMEOUT = 8 and i_mem_ack never asserted -> o_mem_req high for exactly 8 cycles, then o_data_ack = 1, o_data_err = 1, o_data_rdata = 0. Ack arriving on cycle 8 -> err = 0.

REQ-027 Reset mid-transaction: i_rst for 1 cycle while in DATA -> o_mem_req = 0 at the next edge, no ack pulse; a subsequent stray i_mem_ack is ignored; a fresh i_inst_req is then serviced normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus bundle for mem_arbiter: fetch port, load/store port and memory port.
// Signal names are from the arbiter's point of view (i_ = into arbiter, o_ = out of arbiter).
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();
  logic            i_inst_req;
  logic [XLEN-1:0] i_inst_addr;
  logic            o_inst_ack;
  logic [XLEN-1:0] o_inst_rdata;
  logic            o_inst_err;

  logic            i_data_req;
  logic [XLEN-1:0] i_data_addr;
  logic [XLEN-1:0] i_data_wdata;
  logic [2:0]      i_data_funct3;
  logic            i_data_we;
  logic            o_data_ack;
  logic [XLEN-1:0] o_data_rdata;
  logic            o_data_err;

  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [2:0]      o_mem_funct3;
  logic            o_mem_we;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  // Arbiter side
  modport slave (
    input  i_inst_req, i_inst_addr,
    output o_inst_ack, o_inst_rdata, o_inst_err,
    input  i_data_req, i_data_addr, i_data_wdata, i_data_funct3, i_data_we,
    output o_data_ack, o_data_rdata, o_data_err,
    output o_mem_req, o_mem_addr, o_mem_wdata, o_mem_funct3, o_mem_we,
    input  i_mem_ack, i_mem_rdata
  );

  // Requesters and memory side
  modport master (
    output i_inst_req, i_inst_addr,
    input  o_inst_ack, o_inst_rdata, o_inst_err,
    output i_data_req, i_data_addr, i_data_wdata, i_data_funct3, i_data_we,
    input  o_data_ack, o_data_rdata, o_data_err,
    input  o_mem_req, o_mem_addr, o_mem_wdata, o_mem_funct3, o_mem_we,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port, with data-streak
// fairness limit and memory-wait timeout. All outputs are registered.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_arbiter_if.slave  bus
);
  // state | meaning
  // IDLE  | arbitrate between pending requests
  // INST  | fetch owns the memory port, waiting for ack/timeout
  // DATA  | load/store owns the memory port, waiting for ack/timeout
  // RESP  | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

  localparam logic [15:0] STREAK_MAX = 16'(MAX_STREAK);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_t          r_state, w_state;
  logic [15:0]     r_streak, w_streak;
  logic [15:0]     r_wait, w_wait;
  logic            r_mem_req, w_mem_req;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata;
  logic [2:0]      r_mem_funct3, w_mem_funct3;
  logic            r_mem_we, w_mem_we;
  logic            r_inst_ack, w_inst_ack;
  logic            r_inst_err, w_inst_err;
  logic [XLEN-1:0] r_inst_rdata, w_inst_rdata;
  logic            r_data_ack, w_data_ack;
  logic            r_data_err, w_data_err;
  logic [XLEN-1:0] r_data_rdata, w_data_rdata;
  logic            w_grant_inst, w_grant_data;

  always_comb begin
    w_state      = r_state;
    w_streak     = r_streak;
    w_wait       = r_wait;
    w_mem_req    = r_mem_req;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_funct3 = r_mem_funct3;
    w_mem_we     = r_mem_we;
    w_inst_ack   = 1'b0;
    w_inst_err   = r_inst_err;
    w_inst_rdata = r_inst_rdata;
    w_data_ack   = 1'b0;
    w_data_err   = r_data_err;
    w_data_rdata = r_data_rdata;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_data = bus.i_data_req && (!bus.i_inst_req || (r_streak < STREAK_MAX));
        w_grant_inst = bus.i_inst_req && !w_grant_data;
        // Streak only counts data grants that made a fetch wait
        if (!bus.i_inst_req || w_grant_inst)
          w_streak = '0;
        else if (w_grant_data && (r_streak < STREAK_MAX))
          w_streak = r_streak + 16'd1;
        if (w_grant_data) begin
          w_state      = DATA;
          w_wait       = '0;
          w_mem_req    = 1'b1;
          w_mem_addr   = bus.i_data_addr;
          w_mem_wdata  = bus.i_data_wdata;
          w_mem_funct3 = bus.i_data_funct3;
          w_mem_we     = bus.i_data_we;
        end else if (w_grant_inst) begin
          w_state      = INST;
          w_wait       = '0;
          w_mem_req    = 1'b1;
          w_mem_addr   = bus.i_inst_addr;
          w_mem_wdata  = '0;
          w_mem_funct3 = 3'b010;
          w_mem_we     = 1'b0;
        end
      end
      INST, DATA: begin
        if (bus.i_mem_ack) begin
          w_state   = RESP;
          w_mem_req = 1'b0;
          if (r_state == INST) begin
            w_inst_ack   = 1'b1;
            w_inst_err   = 1'b0;
            w_inst_rdata = bus.i_mem_rdata;
          end else begin
            w_data_ack   = 1'b1;
            w_data_err   = 1'b0;
            w_data_rdata = bus.i_mem_rdata;
          end
        end else if (r_wait >= WAIT_LAST) begin
          w_state   = RESP;
          w_mem_req = 1'b0;
          if (r_state == INST) begin
            w_inst_ack   = 1'b1;
            w_inst_err   = 1'b1;
            w_inst_rdata = '0;
          end else begin
            w_data_ack   = 1'b1;
            w_data_err   = 1'b1;
            w_data_rdata = '0;
          end
        end else begin
          w_wait = r_wait + 16'd1;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_wait       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_funct3 <= '0;
      r_mem_we     <= 1'b0;
      r_inst_ack   <= 1'b0;
      r_inst_err   <= 1'b0;
      r_inst_rdata <= '0;
      r_data_ack   <= 1'b0;
      r_data_err   <= 1'b0;
      r_data_rdata <= '0;
    end else begin
      r_state      <= w_state;
      r_streak     <= w_streak;
      r_wait       <= w_wait;
      r_mem_req    <= w_mem_req;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_funct3 <= w_mem_funct3;
      r_mem_we     <= w_mem_we;
      r_inst_ack   <= w_inst_ack;
      r_inst_err   <= w_inst_err;
      r_inst_rdata <= w_inst_rdata;
      r_data_ack   <= w_data_ack;
      r_data_err   <= w_data_err;
      r_data_rdata <= w_data_rdata;
    end
  end

  assign bus.o_mem_req    = r_mem_req;
  assign bus.o_mem_addr   = r_mem_addr;
  assign bus.o_mem_wdata  = r_mem_wdata;
  assign bus.o_mem_funct3 = r_mem_funct3;
  assign bus.o_mem_we     = r_mem_we;
  assign bus.o_inst_ack   = r_inst_ack;
  assign bus.o_inst_err   = r_inst_err;
  assign bus.o_inst_rdata = r_inst_rdata;
  assign bus.o_data_ack   = r_data_ack;
  assign bus.o_data_err   = r_data_err;
  assign bus.o_data_rdata = r_data_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected transactions are queued when requests are
// raised and checked when the memory port and the completion pulses appear.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(
    .XLEN(32), .MAX_STREAK(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] rd;
    logic        err;
    int          delay;
  } txn_t;

  txn_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] sh_inst_rd = '0;
  logic [31:0] sh_data_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_inst, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic we, input logic [31:0] rd,
                      input logic err, input int delay);
    txn_t e;
    e.is_inst = is_inst; e.addr = addr; e.wdata = wdata; e.f3 = f3;
    e.we = we; e.rd = rd; e.err = err; e.delay = delay;
    sb.push_back(e);
  endtask

  task automatic wait_grant(output bit ok);
    int cyc = 0;
    while (bus.o_mem_req !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = (bus.o_mem_req === 1'b1);
    if (!ok) chk("grant_seen", 32'(bus.o_mem_req), 32'd1);
  endtask

  task automatic check_port(input txn_t e);
    chk("mem_addr", bus.o_mem_addr, e.addr);
    chk("mem_wdata", bus.o_mem_wdata, e.wdata);
    chk("mem_funct3", 32'(bus.o_mem_funct3), 32'(e.f3));
    chk("mem_we", 32'(bus.o_mem_we), 32'(e.we));
  endtask

  task automatic check_resp(input txn_t e);
    chk("mem_req_low", 32'(bus.o_mem_req), 32'd0);
    chk("inst_ack", 32'(bus.o_inst_ack), 32'(e.is_inst));
    chk("data_ack", 32'(bus.o_data_ack), 32'(!e.is_inst));
    if (e.is_inst) begin
      chk("inst_rdata", bus.o_inst_rdata, e.rd);
      chk("inst_err", 32'(bus.o_inst_err), 32'(e.err));
      chk("data_rdata_kept", bus.o_data_rdata, sh_data_rd);
      sh_inst_rd = e.rd;
    end else begin
      chk("data_rdata", bus.o_data_rdata, e.rd);
      chk("data_err", 32'(bus.o_data_err), 32'(e.err));
      chk("inst_rdata_kept", bus.o_inst_rdata, sh_inst_rd);
      sh_data_rd = e.rd;
    end
    @(negedge clk);
    chk("ack_pulse_end", {30'b0, bus.o_inst_ack, bus.o_data_ack}, 32'd0);
  endtask

  task automatic run_txn(input bit drop);
    txn_t e;
    bit ok;
    wait_grant(ok);
    if (!ok) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check_port(e);
    if (drop) begin
      bus.i_inst_req = 1'b0;
      bus.i_data_req = 1'b0;
    end
    repeat (e.delay - 1) begin
      @(negedge clk);
      chk("mem_req_hold", 32'(bus.o_mem_req), 32'd1);
      check_port(e);
    end
    bus.i_mem_ack = 1'b1;
    bus.i_mem_rdata = e.rd;
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdata = $urandom;
    check_resp(e);
  endtask

  task automatic run_timeout(input int ack_at);
    txn_t e;
    bit ok;
    int cnt = 0;
    wait_grant(ok);
    if (!ok) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check_port(e);
    bus.i_data_req = 1'b0;
    while (bus.o_mem_req === 1'b1 && cnt < 30) begin
      cnt++;
      bus.i_mem_ack = (cnt == ack_at);
      bus.i_mem_rdata = 32'h600DF00D;
      @(negedge clk);
    end
    bus.i_mem_ack = 1'b0;
    chk("req_cycles", 32'(cnt), 32'd8);
    check_resp(e);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.o_mem_req), 32'd0);
    chk({tag, "_acks"}, {30'b0, bus.o_inst_ack, bus.o_data_ack}, 32'd0);
    chk({tag, "_inst_rd"}, bus.o_inst_rdata, sh_inst_rd);
    chk({tag, "_data_rd"}, bus.o_data_rdata, sh_data_rd);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    bus.i_inst_req = 1'b1;
    bus.i_inst_addr = 32'h0000_0ABC;
    bus.i_data_req = 1'b0;
    bus.i_data_addr = '0;
    bus.i_data_wdata = '0;
    bus.i_data_funct3 = '0;
    bus.i_data_we = 1'b0;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdata = '0;

    // reset with a fetch pending: nothing may be granted
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    chk("rst_mem_funct3", 32'(bus.o_mem_funct3), 32'd0);
    chk("rst_errs", {30'b0, bus.o_inst_err, bus.o_data_err}, 32'd0);
    check_quiet("rst");
    bus.i_inst_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // single fetch, memory answers two cycles after the request
    push(1'b1, 32'h100, 32'h0, 3'b010, 1'b0, 32'h0050_0093, 1'b0, 2);
    bus.i_inst_addr = 32'h100;
    bus.i_inst_req = 1'b1;
    run_txn(1'b1);

    // store
    push(1'b0, 32'h2000, 32'hDEAD_BEEF, 3'b000, 1'b1, 32'h1234_5678, 1'b0, 1);
    bus.i_data_addr = 32'h2000;
    bus.i_data_wdata = 32'hDEAD_BEEF;
    bus.i_data_funct3 = 3'b000;
    bus.i_data_we = 1'b1;
    bus.i_data_req = 1'b1;
    run_txn(1'b1);

    // contention: both held high, expect D D D D I repeating
    bus.i_inst_addr = 32'h200;
    bus.i_data_addr = 32'h3000;
    bus.i_data_wdata = 32'h55;
    bus.i_data_funct3 = 3'b100;
    bus.i_data_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push(1'b1, 32'h200, 32'h0, 3'b010, 1'b0, $urandom, 1'b0, 1);
      else            push(1'b0, 32'h3000, 32'h55, 3'b100, 1'b0, $urandom, 1'b0, 1);
    end
    bus.i_inst_req = 1'b1;
    bus.i_data_req = 1'b1;
    for (int i = 0; i < 10; i++) run_txn(i == 9);

    // stray ack in IDLE
    @(negedge clk);
    bus.i_mem_ack = 1'b1;
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    check_quiet("stray_idle");
    @(negedge clk);
    check_quiet("stray_idle2");

    // timeout with no ack, then ack landing on the last wait cycle
    bus.i_data_addr = 32'h4000;
    bus.i_data_funct3 = 3'b010;
    bus.i_data_we = 1'b0;
    push(1'b0, 32'h4000, 32'h55, 3'b010, 1'b0, 32'h0, 1'b1, 0);
    bus.i_data_req = 1'b1;
    run_timeout(0);
    push(1'b0, 32'h4000, 32'h55, 3'b010, 1'b0, 32'h600D_F00D, 1'b0, 0);
    bus.i_data_req = 1'b1;
    run_timeout(8);

    // reset in the middle of a load
    bus.i_data_addr = 32'h5000;
    bus.i_data_req = 1'b1;
    wait_grant(ok);
    bus.i_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sh_inst_rd = '0;
    sh_data_rd = '0;
    chk("rstmid_err", {30'b0, bus.o_inst_err, bus.o_data_err}, 32'd0);
    check_quiet("rstmid");
    bus.i_mem_ack = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    check_quiet("late_ack");
    @(negedge clk);
    check_quiet("late_ack2");

    // fresh fetch after reset
    push(1'b1, 32'h300, 32'h0, 3'b010, 1'b0, 32'h0000_0013, 1'b0, 1);
    bus.i_inst_addr = 32'h300;
    bus.i_inst_req = 1'b1;
    run_txn(1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
